// File: rtl/pipeline_collect.sv
// Many-to-one collector: gathers beats until i_last or MAX_BEATS, then presents one token (count/overflow).
// Token valid 1 cycle after the closing beat; i_ready = !o_valid || o_ready, so a stalled token blocks new beats.
module pipeline_collect #(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             i_ready,
  output logic             i_cen,
  output logic             i_first,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_cen,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BEATS);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] count_nxt;
  logic             ovf_nxt;
  logic             close;

  assign o_valid = (state == HOLD);
  assign i_ready = !o_valid || o_ready;
  assign i_cen   = i_valid && i_ready;
  assign o_cen   = o_valid && o_ready;
  assign i_first = (cnt == '0);
  assign cnt_inc = cnt + CNT_W'(1);
  assign close   = i_cen && (i_last || (cnt_inc == MAX_C));

  // A closing beat always (re)loads the token, even while the old one is leaving.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    count_nxt = o_count;
    ovf_nxt   = o_overflow;
    if (close) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
      count_nxt = cnt_inc;
      ovf_nxt   = !i_last;
    end else begin
      if (i_cen) begin
        cnt_nxt = cnt_inc;
      end
      if (o_cen) begin
        state_nxt = COLLECT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= COLLECT;
      cnt        <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_count    <= count_nxt;
      o_overflow <= ovf_nxt;
    end
  end

endmodule
